fridge_ctrl_multi: RTL and testbench
====================================

Name: fridge_ctrl_multi

Overview:
- Clocked, parametrised successor to the combinational fridge/freezer controller.
- Holds per-compartment temperature setpoints, capacity levels and ice-maker enable in registers written through a single command port.
- Runs a per-compartment hysteresis thermostat and one shared compressor FSM with a minimum-off timer.
- Sits between the front-panel decoder and the compressor/ice-maker drivers.

Parameters:
- NCOMP, 2, number of compartments; index NCOMP-1 is the freezer.
- TW, 5, temperature and setpoint width, unsigned.
- CW, 8, capacity width.
- CAP_UNIT, 25, capacity step size.
- HYST, 1, thermostat hysteresis in temperature LSBs.
- MIN_OFF, 16, minimum compressor off time in clocks (>=1).
- SP_RST, 5'd4, reset setpoint for every compartment.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous and active-high.
- pwr  in  1  mains enable.
- wr_en  in  1  command strobe, one cycle per command.
- sel_func  in  2  command function: 0 setpoint, 1 capacity, 2 ice enable, 3 reserved.
- sel_comp  in  $clog2(NCOMP)  target compartment.
- wdata  in  TW  command data.
- meas_temp  in  NCOMP*TW  measured temperatures, packed; compartment k at [k*TW +: TW].
- setpt  out  NCOMP*TW  registered setpoints.
- cap  out  NCOMP*CW  registered capacities.
- cool_req  out  NCOMP  per-compartment cooling demand.
- comp_on  out  1  compressor drive.
- ice  out  1  ice-maker drive.
- err  out  1  one-cycle pulse on an illegal command.

Behaviour:
- Reset (async, rst=1): every setpt slice = SP_RST; every cap slice = CAP_UNIT; ice_en=0; cool_req=0; comp_on=0; ice=0; err=0; compressor FSM = OFF_HOLD with off counter = MIN_OFF.
- Reset asserted mid-operation takes effect immediately, with no completion of the current cycle.
- Commands are accepted only when wr_en=1 and pwr=1. Registers update on that clock edge and are visible one cycle later.
  - sel_func=0: setpt[sel_comp] <= wdata.
  - sel_func=1: cap[sel_comp] <= (wdata[1:0]+1)*CAP_UNIT, computed at CW+1 bits and saturated to 2^CW-1 on overflow. Defaults give 25, 50, 75, 100.
  - sel_func=2: ice_en <= wdata[0]; sel_comp is ignored.
  - sel_func=3, or sel_comp >= NCOMP: no register changes; err=1 for exactly one cycle.
  - wr_en=1 with pwr=0: ignored, no err.
- Thermostat, per compartment k, registered:
  - Set cool_req[k]=1 when meas > setpt+HYST.
  - Clear cool_req[k]=0 when meas+HYST <= setpt.
  - Otherwise hold.
  - Compare at TW+1 bits so there is no wrap-around.
  - A setpoint written this cycle is used for comparison from the next cycle.
- Compressor FSM:
  - OFF_HOLD: counter decrements each cycle; at 0, go to OFF_READY.
  - OFF_READY: if any cool_req is set, go to ON.
  - ON: comp_on=1. When all cool_req are 0, go to OFF_HOLD with counter = MIN_OFF and comp_on=0 on that same edge.
  - comp_on is a registered output equal to (state==ON).
  - cool_req rising while in OFF_HOLD does not shorten the hold.
- Ice maker: ice <= ice_en & comp_on & (meas[NCOMP-1] <= setpt[NCOMP-1]), registered. Clearing ice_en drops ice on the next edge.
- pwr=0, synchronous: cool_req, comp_on, ice and err are forced to 0; FSM goes to OFF_HOLD with counter = MIN_OFF. setpt, cap and ice_en are retained.
- pwr rising behaves like an exit from OFF_HOLD: the full MIN_OFF wait applies before the compressor can start.

Decomposition:
- Shared package fridge_pkg holds:
  - function codes FN_SETPT=0, FN_CAP=1, FN_ICE=2, FN_RSVD=3;
  - compressor state enum OFF_HOLD, OFF_READY, ON;
  - default CAP_UNIT.
- One sub-module, fridge_thermostat: a single compartment's hysteresis comparator plus cool_req register, instantiated NCOMP times in a generate loop.

Test Plan:
1. Reset, then release; hold pwr=1 with no writes → setpt slices all 4, cap slices all 25, comp_on=0 for 16 cycles.
2. Write sel_func=0, sel_comp=1, wdata=2; drive meas_temp[1]=10 → setpt[1]=2 on the next cycle; cool_req[1]=1 the cycle after; comp_on=1 once the 16-cycle hold has expired.
3. While ON, lower meas_temp[1] to 3, then to 1 → cool_req[1] holds at 3 and clears at 1; comp_on falls; setting meas_temp[1]=10 again keeps comp_on=0 for 16 cycles.
4. Write sel_func=1, wdata=3 → cap=100. With CW=6, CAP_UNIT=25, wdata=3 → cap saturates to 63.
5. Write sel_func=3; separately write sel_comp=2 with NCOMP=2 → err=1 for one cycle each, all registers unchanged.
6. Set ice_en=1, comp_on=1, meas_temp[1]=2, setpt[1]=2 → ice=1. Drop pwr → ice, comp_on and cool_req are 0 next cycle, setpt retained. Assert rst mid-ON → comp_on=0 immediately.

Source files
------------

// File: rtl/fridge_pkg.sv
// Shared definitions for the multi-compartment fridge controller: command
// function codes, compressor states and the default capacity step.
package fridge_pkg;

    localparam logic [1:0] FN_SETPT = 2'd0;
    localparam logic [1:0] FN_CAP   = 2'd1;
    localparam logic [1:0] FN_ICE   = 2'd2;
    localparam logic [1:0] FN_RSVD  = 2'd3;

    localparam int CAP_UNIT_DEF = 25;

    typedef enum logic [1:0] {
        OFF_HOLD  = 2'd0,
        OFF_READY = 2'd1,
        ON        = 2'd2
    } comp_state_t;

endpackage

// File: rtl/fridge_ctrl_multi_if.sv
// Command port from the front-panel decoder: one write strobe per command,
// with the illegal-command pulse returned to the decoder.
interface fridge_ctrl_multi_if #(
    parameter int NCOMP = 2,
    parameter int TW    = 5
);
    localparam int SCW = (NCOMP > 1) ? $clog2(NCOMP) : 1;

    logic           wr_en;
    logic [1:0]     sel_func;
    logic [SCW-1:0] sel_comp;
    logic [TW-1:0]  wdata;
    logic           err;

    modport master (output wr_en, sel_func, sel_comp, wdata, input err);
    modport slave  (input wr_en, sel_func, sel_comp, wdata, output err);

endinterface

// File: rtl/fridge_thermostat.sv
// One compartment's hysteresis thermostat; comparisons are widened by a bit
// so setpoint+HYST near full scale never wraps.
module fridge_thermostat #(
    parameter int TW   = 5,
    parameter int HYST = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwr,
    input  logic [TW-1:0] meas,
    input  logic [TW-1:0] setpt,
    output logic          cool_req
);

    logic [TW:0] meas_x;
    logic [TW:0] sp_x;
    logic [TW:0] hyst_x;

    assign meas_x = {1'b0, meas};
    assign sp_x   = {1'b0, setpt};
    assign hyst_x = (TW+1)'(HYST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cool_req <= 1'b0;
        end else if (!pwr) begin
            cool_req <= 1'b0;
        end else if (meas_x > sp_x + hyst_x) begin
            cool_req <= 1'b1;
        end else if (meas_x + hyst_x <= sp_x) begin
            cool_req <= 1'b0;
        end
    end

endmodule

// File: rtl/fridge_ctrl_multi.sv
// Clocked multi-compartment fridge controller: command-written setpoint,
// capacity and ice registers, per-compartment thermostats, shared compressor.
module fridge_ctrl_multi
    import fridge_pkg::*;
#(
    parameter int            NCOMP    = 2,
    parameter int            TW       = 5,
    parameter int            CW       = 8,
    parameter int            CAP_UNIT = CAP_UNIT_DEF,
    parameter int            HYST     = 1,
    parameter int            MIN_OFF  = 16,
    parameter logic [TW-1:0] SP_RST   = TW'(4)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pwr,
    fridge_ctrl_multi_if.slave    cmd,
    input  logic [NCOMP*TW-1:0]   meas_temp,
    output logic [NCOMP*TW-1:0]   setpt,
    output logic [NCOMP*CW-1:0]   cap,
    output logic [NCOMP-1:0]      cool_req,
    output logic                  comp_on,
    output logic                  ice
);

    localparam int SCW  = (NCOMP > 1) ? $clog2(NCOMP) : 1;
    localparam int CNTW = $clog2(MIN_OFF + 1);

    logic        cmd_ok;
    logic        bad_comp;
    logic        bad_cmd;
    logic        ice_en;
    logic [CW:0] cap_prod;
    logic [CW-1:0] cap_new;

    comp_state_t     state;
    comp_state_t     state_nx;
    logic [CNTW-1:0] off_cnt;
    logic [CNTW-1:0] off_cnt_nx;

    assign cmd_ok = cmd.wr_en & pwr;

    // A compartment index can only be out of range when NCOMP is not a power of two.
    generate
        if ((1 << SCW) == NCOMP) begin : g_comp_full
            assign bad_comp = 1'b0;
        end else begin : g_comp_part
            assign bad_comp = (int'(cmd.sel_comp) >= NCOMP);
        end
    endgenerate

    assign bad_cmd  = (cmd.sel_func == FN_RSVD) | (bad_comp & (cmd.sel_func != FN_ICE));
    assign cap_prod = ((CW+1)'(cmd.wdata[1:0]) + (CW+1)'(1)) * (CW+1)'(CAP_UNIT);
    assign cap_new  = cap_prod[CW] ? {CW{1'b1}} : cap_prod[CW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            setpt   <= {NCOMP{SP_RST}};
            cap     <= {NCOMP{CW'(CAP_UNIT)}};
            ice_en  <= 1'b0;
            cmd.err <= 1'b0;
        end else begin
            cmd.err <= cmd_ok & bad_cmd;
            if (cmd_ok && !bad_cmd) begin
                case (cmd.sel_func)
                    FN_SETPT: setpt[int'(cmd.sel_comp)*TW +: TW] <= cmd.wdata;
                    FN_CAP:   cap[int'(cmd.sel_comp)*CW +: CW]   <= cap_new;
                    FN_ICE:   ice_en                             <= cmd.wdata[0];
                    default:  ;
                endcase
            end
        end
    end

    for (genvar k = 0; k < NCOMP; k++) begin : g_therm
        fridge_thermostat #(
            .TW   (TW),
            .HYST (HYST)
        ) u_therm (
            .clk      (clk),
            .rst      (rst),
            .pwr      (pwr),
            .meas     (meas_temp[k*TW +: TW]),
            .setpt    (setpt[k*TW +: TW]),
            .cool_req (cool_req[k])
        );
    end

    // Power loss re-arms the full off hold, so a restart always waits MIN_OFF.
    always_comb begin
        state_nx   = state;
        off_cnt_nx = off_cnt;
        case (state)
            OFF_HOLD: begin
                if (off_cnt == '0) state_nx = OFF_READY;
                else               off_cnt_nx = off_cnt - CNTW'(1);
            end
            OFF_READY: begin
                if (|cool_req) state_nx = ON;
            end
            ON: begin
                if (!(|cool_req)) begin
                    state_nx   = OFF_HOLD;
                    off_cnt_nx = CNTW'(MIN_OFF);
                end
            end
            default: begin
                state_nx   = OFF_HOLD;
                off_cnt_nx = CNTW'(MIN_OFF);
            end
        endcase
        if (!pwr) begin
            state_nx   = OFF_HOLD;
            off_cnt_nx = CNTW'(MIN_OFF);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= OFF_HOLD;
            off_cnt <= CNTW'(MIN_OFF);
            comp_on <= 1'b0;
            ice     <= 1'b0;
        end else begin
            state   <= state_nx;
            off_cnt <= off_cnt_nx;
            comp_on <= (state_nx == ON);
            ice     <= pwr & ice_en & comp_on &
                       (meas_temp[(NCOMP-1)*TW +: TW] <= setpt[(NCOMP-1)*TW +: TW]);
        end
    end

endmodule

// File: tb/tb_fridge_ctrl_multi.sv
// Self-checking bench for fridge_ctrl_multi: directed steps then random traffic,
// every cycle compared against a behavioural model of the controller rules.
module tb_fridge_ctrl_multi;

    localparam int NCOMP    = 2;
    localparam int TW       = 5;
    localparam int CW       = 8;
    localparam int CAP_UNIT = 25;
    localparam int HYST     = 1;
    localparam int MIN_OFF  = 16;
    localparam int N2       = 3;
    localparam int CW2      = 6;

    logic clk = 1'b0;
    logic rst;
    logic pwr;
    logic pwr2;

    logic [TW-1:0]         meas_m [NCOMP];
    logic [NCOMP*TW-1:0]   meas_temp;
    logic [NCOMP*TW-1:0]   setpt;
    logic [NCOMP*CW-1:0]   cap;
    logic [NCOMP-1:0]      cool_req;
    logic                  comp_on;
    logic                  ice;

    logic [N2*TW-1:0]      meas_temp2;
    logic [N2*TW-1:0]      setpt2;
    logic [N2*CW2-1:0]     cap2;
    logic [N2-1:0]         cool_req2;
    logic                  comp_on2;
    logic                  ice2;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state
    int sp_m   [NCOMP];
    int cap_m  [NCOMP];
    int cool_m [NCOMP];
    bit ice_en_m;
    bit on_m;
    bit ice_m;
    bit err_m;
    int since_off;

    fridge_ctrl_multi_if #(.NCOMP(NCOMP), .TW(TW)) cmd ();
    fridge_ctrl_multi_if #(.NCOMP(N2), .TW(TW))    cmd2 ();

    assign meas_temp  = {meas_m[1], meas_m[0]};
    assign meas_temp2 = '0;

    fridge_ctrl_multi #(
        .NCOMP(NCOMP), .TW(TW), .CW(CW), .CAP_UNIT(CAP_UNIT),
        .HYST(HYST), .MIN_OFF(MIN_OFF), .SP_RST(5'd4)
    ) dut (
        .clk(clk), .rst(rst), .pwr(pwr), .cmd(cmd.slave),
        .meas_temp(meas_temp), .setpt(setpt), .cap(cap),
        .cool_req(cool_req), .comp_on(comp_on), .ice(ice)
    );

    fridge_ctrl_multi #(
        .NCOMP(N2), .TW(TW), .CW(CW2), .CAP_UNIT(CAP_UNIT),
        .HYST(HYST), .MIN_OFF(MIN_OFF), .SP_RST(5'd4)
    ) dut2 (
        .clk(clk), .rst(rst), .pwr(pwr2), .cmd(cmd2.slave),
        .meas_temp(meas_temp2), .setpt(setpt2), .cap(cap2),
        .cool_req(cool_req2), .comp_on(comp_on2), .ice(ice2)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        for (int k = 0; k < NCOMP; k++) begin
            sp_m[k]   = 4;
            cap_m[k]  = CAP_UNIT;
            cool_m[k] = 0;
        end
        ice_en_m  = 1'b0;
        on_m      = 1'b0;
        ice_m     = 1'b0;
        err_m     = 1'b0;
        since_off = 0;
    endtask

    // Model one clock edge from the inputs and model state seen just before it.
    task automatic modelUpdate();
        int  ncool [NCOMP];
        int  meas;
        int  c;
        bit  any_cool;
        bit  nice;
        bit  nerr;
        int  fn;
        int  comp;
        int  data;
        fn   = int'(cmd.sel_func);
        comp = int'(cmd.sel_comp);
        data = int'(cmd.wdata);
        any_cool = 1'b0;
        for (int k = 0; k < NCOMP; k++) if (cool_m[k] != 0) any_cool = 1'b1;
        for (int k = 0; k < NCOMP; k++) begin
            meas = int'(meas_m[k]);
            if (!pwr)                          ncool[k] = 0;
            else if (meas > sp_m[k] + HYST)    ncool[k] = 1;
            else if (meas + HYST <= sp_m[k])   ncool[k] = 0;
            else                               ncool[k] = cool_m[k];
        end
        nice = pwr && ice_en_m && on_m && (int'(meas_m[NCOMP-1]) <= sp_m[NCOMP-1]);
        nerr = pwr && cmd.wr_en && (fn == 3 || (fn != 2 && comp >= NCOMP));
        if (!pwr) begin
            on_m = 1'b0;
            since_off = 0;
        end else if (on_m) begin
            if (!any_cool) begin
                on_m = 1'b0;
                since_off = 0;
            end
        end else if (since_off >= MIN_OFF + 1 && any_cool) begin
            on_m = 1'b1;
        end else if (since_off < 1000) begin
            since_off++;
        end
        if (pwr && cmd.wr_en && !nerr) begin
            if (fn == 0) sp_m[comp] = data;
            if (fn == 1) begin
                c = ((data % 4) + 1) * CAP_UNIT;
                if (c > (1 << CW) - 1) c = (1 << CW) - 1;
                cap_m[comp] = c;
            end
            if (fn == 2) ice_en_m = data[0];
        end
        for (int k = 0; k < NCOMP; k++) cool_m[k] = ncool[k];
        ice_m = nice;
        err_m = nerr;
    endtask

    task automatic checkOutput(input string step);
        logic [NCOMP*TW-1:0] sp_e;
        logic [NCOMP*CW-1:0] cap_e;
        logic [NCOMP-1:0]    cool_e;
        for (int k = 0; k < NCOMP; k++) begin
            sp_e[k*TW +: TW]  = TW'(sp_m[k]);
            cap_e[k*CW +: CW] = CW'(cap_m[k]);
            cool_e[k]         = (cool_m[k] != 0);
        end
        checkValue({step, " setpt"},    64'(setpt),    64'(sp_e));
        checkValue({step, " cap"},      64'(cap),      64'(cap_e));
        checkValue({step, " cool_req"}, 64'(cool_req), 64'(cool_e));
        checkValue({step, " comp_on"},  64'(comp_on),  64'(on_m));
        checkValue({step, " ice"},      64'(ice),      64'(ice_m));
        checkValue({step, " err"},      64'(cmd.err),  64'(err_m));
    endtask

    task automatic applyStimulus(input string tag, input bit p, input bit w,
                                 input int fn, input int comp, input int data);
        pwr          = p;
        cmd.wr_en    = w;
        cmd.sel_func = 2'(fn);
        cmd.sel_comp = 1'(comp);
        cmd.wdata    = TW'(data);
        @(posedge clk);
        modelUpdate();
        #1;
        checkOutput(tag);
        cmd.wr_en = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic waitCompOn(input string tag);
        for (int i = 0; i < 40 && comp_on !== 1'b1; i++) idle(tag, 1);
        checkValue({tag, " comp_on within budget"}, 64'(comp_on), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        pwr = 1'b0;
        pwr2 = 1'b0;
        cmd.wr_en = 1'b0; cmd.sel_func = '0; cmd.sel_comp = '0; cmd.wdata = '0;
        cmd2.wr_en = 1'b0; cmd2.sel_func = '0; cmd2.sel_comp = '0; cmd2.wdata = '0;
        meas_m[0] = '0;
        meas_m[1] = '0;
        resetModel();
        #12;
        checkOutput("reset");
        checkValue("reset setpt const", 64'(setpt), 64'({5'd4, 5'd4}));
        checkValue("reset cap const", 64'(cap), 64'({8'd25, 8'd25}));
        rst  = 1'b0;
        pwr2 = 1'b1;

        $display("[TB] step 1: idle after reset");
        for (int i = 0; i < 16; i++) begin
            idle("t1 idle", 1);
            checkValue("t1 comp_on held off", 64'(comp_on), 64'd0);
        end
        checkValue("t1 setpt", 64'(setpt), 64'({5'd4, 5'd4}));
        checkValue("t1 cap", 64'(cap), 64'({8'd25, 8'd25}));

        $display("[TB] step 2: setpoint write and cooling demand");
        meas_m[1] = 5'd10;
        applyStimulus("t2 write", 1'b1, 1'b1, 0, 1, 2);
        checkValue("t2 setpt[1]", 64'(setpt[9:5]), 64'd2);
        idle("t2 cool", 1);
        checkValue("t2 cool_req[1]", 64'(cool_req[1]), 64'd1);
        waitCompOn("t2");

        $display("[TB] step 3: hysteresis and minimum off time");
        meas_m[1] = 5'd3;
        idle("t3 hold", 3);
        checkValue("t3 cool_req held", 64'(cool_req[1]), 64'd1);
        checkValue("t3 comp_on held", 64'(comp_on), 64'd1);
        meas_m[1] = 5'd1;
        idle("t3 clear", 1);
        checkValue("t3 cool_req cleared", 64'(cool_req[1]), 64'd0);
        idle("t3 off", 1);
        checkValue("t3 comp_on fell", 64'(comp_on), 64'd0);
        meas_m[1] = 5'd10;
        idle("t3 rehold", 16);
        checkValue("t3 comp_on still held", 64'(comp_on), 64'd0);
        waitCompOn("t3");

        $display("[TB] step 4: capacity writes");
        applyStimulus("t4 cap", 1'b1, 1'b1, 1, 0, 3);
        checkValue("t4 cap[0]=100", 64'(cap[7:0]), 64'd100);
        cmd2.wr_en = 1'b1; cmd2.sel_func = 2'd1; cmd2.sel_comp = 2'd0; cmd2.wdata = 5'd3;
        idle("t4 dut2", 1);
        cmd2.wr_en = 1'b0;
        checkValue("t4 dut2 cap saturates", 64'(cap2[5:0]), 64'd63);
        cmd2.wr_en = 1'b1; cmd2.sel_func = 2'd1; cmd2.sel_comp = 2'd2; cmd2.wdata = 5'd1;
        idle("t4 dut2b", 1);
        cmd2.wr_en = 1'b0;
        checkValue("t4 dut2 cap[2]=50", 64'(cap2[17:12]), 64'd50);

        $display("[TB] step 5: illegal commands");
        applyStimulus("t5 rsvd", 1'b1, 1'b1, 3, 0, 7);
        checkValue("t5 err pulse", 64'(cmd.err), 64'd1);
        idle("t5 after", 1);
        checkValue("t5 err cleared", 64'(cmd.err), 64'd0);
        applyStimulus("t5 nopwr", 1'b0, 1'b1, 3, 0, 7);
        checkValue("t5 err with pwr low", 64'(cmd.err), 64'd0);
        cmd2.wr_en = 1'b1; cmd2.sel_func = 2'd0; cmd2.sel_comp = 2'd3; cmd2.wdata = 5'd9;
        idle("t5 dut2", 1);
        cmd2.wr_en = 1'b0;
        checkValue("t5 dut2 err pulse", 64'(cmd2.err), 64'd1);
        checkValue("t5 dut2 setpt kept", 64'(setpt2), 64'({5'd4, 5'd4, 5'd4}));
        idle("t5 dut2 after", 1);
        checkValue("t5 dut2 err cleared", 64'(cmd2.err), 64'd0);
        checkValue("t5 dut2 quiet", 64'({cool_req2, comp_on2, ice2}), 64'd0);

        $display("[TB] step 6: ice maker, power loss and async reset");
        applyStimulus("t6 ice_en", 1'b1, 1'b1, 2, 0, 1);
        meas_m[1] = 5'd10;
        waitCompOn("t6");
        meas_m[1] = 5'd2;
        idle("t6 ice", 2);
        checkValue("t6 ice on", 64'(ice), 64'd1);
        applyStimulus("t6 pwr off", 1'b0, 1'b0, 0, 0, 0);
        checkValue("t6 ice off", 64'(ice), 64'd0);
        checkValue("t6 comp off", 64'(comp_on), 64'd0);
        checkValue("t6 cool off", 64'(cool_req), 64'd0);
        checkValue("t6 setpt kept", 64'(setpt[9:5]), 64'd2);
        meas_m[1] = 5'd10;
        waitCompOn("t6 repower");
        #3;
        rst = 1'b1;
        #1;
        resetModel();
        checkValue("t6 async comp_on", 64'(comp_on), 64'd0);
        checkValue("t6 async setpt", 64'(setpt), 64'({5'd4, 5'd4}));
        checkOutput("t6 async");
        #2;
        rst = 1'b0;

        $display("[TB] random phase");
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NCOMP; k++)
                if ($urandom_range(0, 3) == 0) meas_m[k] = TW'($urandom_range(0, 12));
            applyStimulus("rand", ($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 12)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
